// File: rtl/conv_window_reader.sv
// conv_window_reader: issues buffer reads in sliding-window order and streams pixels over valid/ready
// Ports: i_clk/i_nrst clock and async active-low reset; i_start frame start (IDLE only);
// o_busy/o_done frame status; o_read_en/o_read_addr/i_read_data buffer port with one-cycle read latency;
// o_data/o_valid/i_ready pixel stream; o_win_last marks the K*K-th pixel of a window, o_last the frame end.
module conv_window_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int K          = 3,
  parameter int STRIDE     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_read_en,
  output logic [ADDR_WIDTH-1:0] o_read_addr,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_win_last,
  output logic                  o_last
);
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam logic [ADDR_WIDTH-1:0] A1   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] KM1  = ADDR_WIDTH'(K - 1);
  localparam logic [ADDR_WIDTH-1:0] OWM1 = ADDR_WIDTH'(OUT_W - 1);
  localparam logic [ADDR_WIDTH-1:0] OHM1 = ADDR_WIDTH'(OUT_H - 1);
  localparam logic [ADDR_WIDTH-1:0] STR  = ADDR_WIDTH'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] IW   = ADDR_WIDTH'(IMG_W);
  if (STRIDE < 1 || K < 1 || K > IMG_W || K > IMG_H || (IMG_W - K) % STRIDE != 0 ||
      (IMG_H - K) % STRIDE != 0 || IMG_W * IMG_H > (1 << ADDR_WIDTH)) begin : g_bad_params
    $error("conv_window_reader: illegal parameter set");
  end
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_wc, r_wr, r_oc, r_or, w_addr;
  logic r_in_flight, r_if_wl, r_if_last, r_done;
  logic [DATA_WIDTH-1:0] r_fd [2];
  logic [1:0] r_fwl, r_fl, r_cnt;
  logic r_wp, r_rp;
  logic w_pop, w_issue, w_wc_end, w_wr_end, w_oc_end, w_or_end, w_wl, w_last;
  assign w_wc_end = r_wc == KM1;
  assign w_wr_end = r_wr == KM1;
  assign w_oc_end = r_oc == OWM1;
  assign w_or_end = r_or == OHM1;
  assign w_wl     = w_wc_end && w_wr_end;
  assign w_last   = w_wl && w_oc_end && w_or_end;
  assign w_addr   = (r_or * STR + r_wr) * IW + r_oc * STR + r_wc;
  assign o_valid    = r_cnt != 2'd0;
  assign o_data     = o_valid ? r_fd[r_rp] : '0;
  assign o_win_last = o_valid && r_fwl[r_rp];
  assign o_last     = o_valid && r_fl[r_rp];
  assign w_pop      = o_valid && i_ready;
  // FIFO occupancy plus the read still in flight must leave room for the new read.
  assign w_issue = {1'b0, r_cnt} + {2'b00, r_in_flight} < 3'd2 + {2'b00, w_pop};
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == DRAIN && w_next == IDLE;
    end
  end
  always_comb begin
    w_next = (r_state == IDLE && i_start) ? RUN :
             (r_state == RUN && o_read_en && w_last) ? DRAIN :
             (r_state == DRAIN && w_pop && o_last) ? IDLE : r_state;
  end
  always_comb begin
    o_busy      = r_state != IDLE;
    o_done      = r_done;
    o_read_en   = r_state == RUN && w_issue;
    o_read_addr = o_read_en ? w_addr : '0;
  end
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      {r_wc, r_wr, r_oc, r_or} <= '0;
    end else if (r_state == IDLE && i_start) begin
      {r_wc, r_wr, r_oc, r_or} <= '0;
    end else if (o_read_en) begin
      r_wc <= w_wc_end ? '0 : r_wc + A1;
      r_wr <= w_wc_end ? (w_wr_end ? '0 : r_wr + A1) : r_wr;
      r_oc <= w_wl ? (w_oc_end ? '0 : r_oc + A1) : r_oc;
      r_or <= (w_wl && w_oc_end) ? (w_or_end ? '0 : r_or + A1) : r_or;
    end
  end
  // Markers travel with the read so they land in the FIFO beside their pixel.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_in_flight <= 1'b0;
      r_if_wl     <= 1'b0;
      r_if_last   <= 1'b0;
      r_fd[0]     <= '0;
      r_fd[1]     <= '0;
      r_fwl       <= '0;
      r_fl        <= '0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_in_flight <= o_read_en;
      r_if_wl     <= o_read_en && w_wl;
      r_if_last   <= o_read_en && w_last;
      if (r_in_flight) begin
        r_fd[r_wp]  <= i_read_data;
        r_fwl[r_wp] <= r_if_wl;
        r_fl[r_wp]  <= r_if_last;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, r_in_flight} - {1'b0, w_pop};
    end
  end
endmodule
